// File: rtl/load_unit.sv
// load_unit
// Read-side data path for OPCODE_LOAD accesses. It takes one load request
// at a time, reads one or two aligned words from data memory, then picks out
// the addressed bytes (little-endian). The result is sign- or zero-extended
// to XLEN and handed to writeback. An access that crosses a word boundary
// is split into two reads, and the two words are merged.
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   req_valid       load request present
//   req_ready       unit idle and able to accept a request
//   req_addr        byte address of the load
//   req_width       0=byte, 1=halfword, 2=word, 3=illegal
//   req_unsigned    1 zero-extends, 0 sign-extends (ignored for words)
//   mem_rd_valid    read command valid
//   mem_rd_ready    memory accepts the read command
//   mem_rd_addr     word-aligned read address
//   mem_rdata_valid read data beat returned
//   mem_rdata       read data word
//   resp_valid      load result valid
//   resp_ready      writeback consumes the result
//   resp_data       extended load result (0 on error)
//   resp_err        request had an illegal width
module load_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_width,
  input  logic            req_unsigned,
  output logic            mem_rd_valid,
  input  logic            mem_rd_ready,
  output logic [XLEN-1:0] mem_rd_addr,
  input  logic            mem_rdata_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    WAIT0 = 3'd2,
    RD1   = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [XLEN-1:0] addr_q;
  logic [1:0]      width_q;
  logic            unsigned_q;
  logic [XLEN-1:0] word0_q;
  logic [XLEN-1:0] word1_q;

  logic [3:0]        nbytes;
  logic              split;
  logic              illegal;
  logic [XLEN-1:0]   word_addr;
  logic [2*XLEN-1:0] shifted;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   merged;

  // Access size and split detection all come from the captured request.
  always_comb begin
    nbytes = 4'd4;
    case (width_q)
      2'd0:    nbytes = 4'd1;
      2'd1:    nbytes = 4'd2;
      default: nbytes = 4'd4;
    endcase
  end

  assign illegal   = (width_q == 2'd3);
  assign split     = ({2'b00, addr_q[1:0]} + nbytes) > 4'd4;
  assign word_addr = {addr_q[XLEN-1:2], 2'b00};

  // The concatenation {word1, word0} lets one shift serve aligned and split
  // accesses. For an unsplit access, word1 only fills bytes above nbytes,
  // and the extension step discards those bytes.
  assign shifted = {word1_q, word0_q} >> {addr_q[1:0], 3'b000};
  assign raw     = shifted[XLEN-1:0];

  always_comb begin
    merged = raw;
    case (width_q)
      2'd0:    merged = {{(XLEN-8){~unsigned_q & raw[7]}}, raw[7:0]};
      2'd1:    merged = {{(XLEN-16){~unsigned_q & raw[15]}}, raw[15:0]};
      default: merged = raw;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. IDLE deliberately ignores mem_rdata_valid. As a
  // result, a beat still in flight when a reset aborts a load is dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = (req_width == 2'd3) ? RESP : RD0;
        end
      end
      RD0: begin
        if (mem_rd_ready) next_state = WAIT0;
      end
      WAIT0: begin
        if (mem_rdata_valid) next_state = split ? RD1 : RESP;
      end
      RD1: begin
        if (mem_rd_ready) next_state = WAIT1;
      end
      WAIT1: begin
        if (mem_rdata_valid) next_state = RESP;
      end
      RESP: begin
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic. The read address comes only from registered state.
  // It therefore holds steady while a command waits for mem_rd_ready.
  // The second read wraps naturally at the top of the address space.
  always_comb begin
    req_ready    = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_addr  = '0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_data    = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      RD0: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = word_addr;
      end
      RD1: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = word_addr + XLEN'(4);
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = illegal;
        resp_data  = illegal ? '0 : merged;
      end
      default: ;
    endcase
  end

  // Request capture and data beats. word1 is cleared on capture, so an
  // unsplit load never carries bytes left over from an earlier load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      width_q    <= '0;
      unsigned_q <= 1'b0;
      word0_q    <= '0;
      word1_q    <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q     <= req_addr;
        width_q    <= req_width;
        unsigned_q <= req_unsigned;
        word0_q    <= '0;
        word1_q    <= '0;
      end
      if (state == WAIT0 && mem_rdata_valid) word0_q <= mem_rdata;
      if (state == WAIT1 && mem_rdata_valid) word1_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit
// Directed bench for load_unit. A small memory responder answers each
// accepted read one cycle later, using words the bench places in an
// associative array. A table of loads with hand-computed results is
// applied in a loop. Hand-written sequences then cover stalls on both
// handshakes and a reset issued in the middle of a load.
module tb_load_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_width;
  logic        req_unsigned;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log [$];
  bit          auto_mem;
  bit          force_beat;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_reads;
  } vec_t;

  vec_t vecs [13];

  load_unit #(.XLEN(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_width(req_width),
    .req_unsigned(req_unsigned),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_ready(mem_rd_ready),
    .mem_rd_addr(mem_rd_addr),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: a command accepted at an edge returns its data word
  // from just after that edge until the next edge.
  always @(posedge clk) begin
    logic        hs;
    logic [31:0] a;
    hs = mem_rd_valid && mem_rd_ready;
    a  = mem_rd_addr;
    #1;
    if (hs && auto_mem) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = mem.exists(a) ? mem[a] : 32'h0;
      rd_log.push_back(a);
    end else begin
      mem_rdata_valid = force_beat;
      mem_rdata       = force_beat ? 32'hBADC0DE5 : 32'h0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int          n;
    bit          got;
    logic [31:0] wa;
    wa = {v.addr[31:2], 2'b00};
    mem[wa]          = v.w0;
    mem[wa + 32'd4]  = v.w1;
    rd_log.delete();
    @(negedge clk);
    checkOutput({v.name, " req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_addr     = v.addr;
    req_width    = v.width;
    req_unsigned = v.uns;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n   = 0;
    got = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (resp_valid) got = 1;
    end
    checkOutput({v.name, " resp_valid"}, {31'b0, got}, 32'd1);
    checkOutput({v.name, " latency"}, n,
                v.exp_err ? 32'd1 : (v.exp_reads == 2 ? 32'd5 : 32'd3));
    checkOutput({v.name, " data"}, resp_data, v.exp_data);
    checkOutput({v.name, " err"}, {31'b0, resp_err}, {31'b0, v.exp_err});
    checkOutput({v.name, " reads"}, rd_log.size(), v.exp_reads);
    if (rd_log.size() >= 1) checkOutput({v.name, " addr0"}, rd_log[0], wa);
    if (rd_log.size() >= 2) checkOutput({v.name, " addr1"}, rd_log[1], wa + 32'd4);
  endtask

  initial begin
    int  n;
    bit  got;

    vecs[0]  = '{"LW_aligned",  32'h0000_0100, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1};
    vecs[1]  = '{"LB_neg",      32'h0000_0103, 2'd0, 1'b0, 32'h80112233, 32'h0,        32'hFFFFFF80, 1'b0, 1};
    vecs[2]  = '{"LBU",         32'h0000_0103, 2'd0, 1'b1, 32'h80112233, 32'h0,        32'h00000080, 1'b0, 1};
    vecs[3]  = '{"LH_split",    32'h0000_0203, 2'd1, 1'b0, 32'hAB000000, 32'h000000CD, 32'hFFFFCDAB, 1'b0, 2};
    vecs[4]  = '{"LW_wrap",     32'hFFFF_FFFE, 2'd2, 1'b0, 32'h22110000, 32'h00004433, 32'h44332211, 1'b0, 2};
    vecs[5]  = '{"illegal",     32'h0000_0040, 2'd3, 1'b0, 32'h12345678, 32'h0,        32'h00000000, 1'b1, 0};
    vecs[6]  = '{"LHU_off2",    32'h0000_0202, 2'd1, 1'b1, 32'h87654321, 32'h0,        32'h00008765, 1'b0, 1};
    vecs[7]  = '{"LH_off2",     32'h0000_0202, 2'd1, 1'b0, 32'h87654321, 32'h0,        32'hFFFF8765, 1'b0, 1};
    vecs[8]  = '{"LB_pos",      32'h0000_0101, 2'd0, 1'b0, 32'h12345678, 32'h0,        32'h00000056, 1'b0, 1};
    vecs[9]  = '{"LW_off1",     32'h0000_0105, 2'd2, 1'b0, 32'h44332211, 32'h88776655, 32'h55443322, 1'b0, 2};
    vecs[10] = '{"LHU_off1",    32'h0000_0301, 2'd1, 1'b1, 32'h00FFEE00, 32'h0,        32'h0000FFEE, 1'b0, 1};
    vecs[11] = '{"LW_unsigned", 32'h0000_0400, 2'd2, 1'b1, 32'h80000000, 32'h0,        32'h80000000, 1'b0, 1};
    vecs[12] = '{"LB_ff",       32'h0000_0000, 2'd0, 1'b0, 32'h000000FF, 32'h0,        32'hFFFFFFFF, 1'b0, 1};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_width    = '0;
    req_unsigned = 1'b0;
    mem_rd_ready = 1'b1;
    resp_ready   = 1'b1;
    auto_mem     = 1'b1;
    force_beat   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst mem_rd_valid", {31'b0, mem_rd_valid}, 32'd0);
    checkOutput("rst mem_rd_addr", mem_rd_addr, 32'd0);
    checkOutput("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst resp_data", resp_data, 32'd0);
    checkOutput("rst resp_err", {31'b0, resp_err}, 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Read command stalled for 3 cycles, then response stalled for 3 cycles
    mem[32'h100] = 32'hDEADBEEF;
    rd_log.delete();
    @(negedge clk);
    mem_rd_ready = 1'b0;
    resp_ready   = 1'b0;
    req_valid    = 1'b1;
    req_addr     = 32'h0000_0100;
    req_width    = 2'd2;
    req_unsigned = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall rd_valid", {31'b0, mem_rd_valid}, 32'd1);
      checkOutput("stall rd_addr", mem_rd_addr, 32'h0000_0100);
      checkOutput("stall req_ready", {31'b0, req_ready}, 32'd0);
    end
    mem_rd_ready = 1'b1;
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid) got = 1;
    end
    checkOutput("stall resp_seen", {31'b0, got}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold resp_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("hold resp_data", resp_data, 32'hDEADBEEF);
      checkOutput("hold req_ready", {31'b0, req_ready}, 32'd0);
    end
    checkOutput("stall reads", rd_log.size(), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("release resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("release req_ready", {31'b0, req_ready}, 32'd1);

    // Illegal width with the response held off
    rd_log.delete();
    resp_ready   = 1'b0;
    req_valid    = 1'b1;
    req_addr     = 32'h0000_0123;
    req_width    = 2'd3;
    req_unsigned = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("err resp_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("err resp_err", {31'b0, resp_err}, 32'd1);
      checkOutput("err resp_data", resp_data, 32'd0);
      checkOutput("err rd_valid", {31'b0, mem_rd_valid}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("err release req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("err reads", rd_log.size(), 32'd0);

    // Reset while waiting for data, followed by a late beat
    auto_mem = 1'b0;
    req_valid    = 1'b1;
    req_addr     = 32'h0000_0100;
    req_width    = 2'd2;
    req_unsigned = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort rd_valid", {31'b0, mem_rd_valid}, 32'd1);
    @(negedge clk);
    checkOutput("abort waiting", {31'b0, mem_rd_valid | req_ready | resp_valid}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    force_beat = 1'b1;
    checkOutput("abort req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    force_beat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort no resp", {31'b0, resp_valid}, 32'd0);
      checkOutput("abort idle", {31'b0, req_ready}, 32'd1);
      checkOutput("abort no rd", {31'b0, mem_rd_valid}, 32'd0);
    end
    auto_mem = 1'b1;
    applyStimulus(vecs[9]);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
